bch_error_corrector: RTL and testbench
======================================

BCH_ERROR_CORRECTOR -- requirements
Module: bch_error_corrector

Interface
REQ-001 Parameter N_WORDS, default 132, gives the number of 32-bit codeword words per block (bit addresses 0..N_WORDS*32-1).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 din_valid  in  1  codeword word valid.
REQ-005 din  in  32  codeword word; bit address = word_index*32 + bit.
REQ-006 din_ready  out  1  buffer accepting codeword words.
REQ-007 err_valid  in  1  one-cycle pulse: serr/aadd1..aadd8 valid (from correct_module).
REQ-008 serr  in  4  number of located errors, 0..8.
REQ-009 aadd1..aadd8  in  13 each  error bit addresses; 8191 = unused slot.
REQ-010 dout_valid  out  1  corrected word valid.
REQ-011 dout  out  32  corrected word.
REQ-012 dout_last  out  1  qualifies the last word of a block.
REQ-013 dout_ready  in  1  downstream accepts dout.
REQ-014 dout_fail  out  1  block uncorrectable (serr>8); stable for the whole output block.
REQ-015 err_drop  out  1  one-cycle pulse: err_valid ignored.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, WAIT_ERR, OUTPUT.
REQ-017 din_ready SHALL be 1 in IDLE and LOAD and 0 otherwise; a beat is accepted only when din_valid and din_ready are both 1.
REQ-018 IDLE: an accepted beat SHALL write word 0, set wr_ptr=1 and go to LOAD.
REQ-019 LOAD: each accepted beat SHALL write word wr_ptr and increment wr_ptr; the beat that writes word N_WORDS-1 SHALL end the load.
REQ-020 Loading words SHALL be non-contiguous-tolerant: idle cycles (din_valid=0) are allowed and do not advance wr_ptr.
REQ-021 When err_valid is asserted in IDLE, LOAD or WAIT_ERR, the block SHALL latch serr and aadd1..8, provided no error set is already latched for the current block.
REQ-022 err_valid arriving in OUTPUT, or when a set is already latched, SHALL be ignored and SHALL pulse err_drop for one cycle.
REQ-023 At the end of load, the FSM SHALL go to OUTPUT if an error set is latched (including one latched in the same cycle), else to WAIT_ERR.
REQ-024 WAIT_ERR SHALL go to OUTPUT on the cycle after err_valid is latched.
REQ-025 Only slots i < serr SHALL be used; slots with address 8191 or address >= N_WORDS*32 SHALL be ignored.
REQ-026 Flip mask for word w = OR over used slots with addr[12:5]==w of (1<<addr[4:0]); duplicate addresses SHALL flip the bit once (OR, not XOR).
REQ-027 When serr > 8, the mask SHALL be forced to 0 and dout_fail SHALL be 1 for the entire block.
REQ-028 dout, dout_valid and dout_last SHALL be registered; dout = buffer[rd_ptr] XOR mask(rd_ptr).
REQ-029 The output register SHALL load the next word when dout_valid==0 or dout_ready==1; while dout_valid=1 and dout_ready=0, dout, dout_valid and dout_last SHALL hold.
REQ-030 The first dout_valid SHALL be asserted exactly 1 cycle after entry to OUTPUT.
REQ-031 dout_last SHALL be 1 only with word N_WORDS-1.
REQ-032 On the handshake of the last word, the FSM SHALL clear the latched error set, wr_ptr, rd_ptr and dout_fail, and return to IDLE; din_ready SHALL rise on the following cycle.
REQ-033 wr_ptr and rd_ptr SHALL be 8 bits wide and SHALL never exceed N_WORDS-1 (no wrap within a block).

Reset
REQ-034 reset SHALL immediately force: state=IDLE, wr_ptr=0, rd_ptr=0, dout_valid=0, dout_last=0, dout=0, dout_fail=0, err_drop=0, latched serr=0, latched addresses=8191; din_ready SHALL be 1 once reset deasserts.
REQ-035 Buffer contents are not reset; reset asserted mid-load or mid-output SHALL abandon the block with no further dout_valid.

Verification
REQ-036 Error-free: load 132 words with word k = k, serr=0 -> 132 outputs with dout=k, dout_last only on word 131, dout_fail=0.
REQ-037 Eight errors: serr=8, addresses 0, 31, 32, 100, 4223, 4000, 64, 65 -> output word 0 = data^0x80000001, word 1 = ^0x00000001, word 2 = ^0x00000003, word 3 = ^0x00000010, word 125 = ^0x00000001, word 131 = ^0x80000000; all other words unchanged.
REQ-038 Early/late error info: (a) err_valid during LOAD at word 50 -> first dout_valid 2 cycles after the last din beat; (b) err_valid 10 cycles after the load ends -> first dout_valid 2 cycles after err_valid. A second err_valid in WAIT_ERR -> err_drop=1 for one cycle, and the first set is used.
REQ-039 Boundary filtering: serr=2 with aadd1 = aadd2 = 37 and aadd3 = 5 -> only word 1 bit 5 flipped; aadd1=5000 -> ignored; serr=9 -> data unmodified, dout_fail=1 for all 132 words.
REQ-040 Backpressure and reset: toggle dout_ready randomly -> the dout sequence is unchanged and held while stalled; assert reset at output word 60 -> dout_valid=0 immediately, din_ready=1 after release, and the next block is processed correctly.

Source files
------------

// File: rtl/bch_error_corrector.sv
// Buffers one BCH codeword block, latches the error locations from the locator,
// then streams the block back out with the located bits flipped.
module bch_error_corrector #(
  parameter int N_WORDS = 132
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din_valid,
  input  logic [31:0] din,
  output logic        din_ready,
  input  logic        err_valid,
  input  logic [3:0]  serr,
  input  logic [12:0] aadd1,
  input  logic [12:0] aadd2,
  input  logic [12:0] aadd3,
  input  logic [12:0] aadd4,
  input  logic [12:0] aadd5,
  input  logic [12:0] aadd6,
  input  logic [12:0] aadd7,
  input  logic [12:0] aadd8,
  output logic        dout_valid,
  output logic [31:0] dout,
  output logic        dout_last,
  input  logic        dout_ready,
  output logic        dout_fail,
  output logic        err_drop,
  output logic [1:0]  state_dbg
);

  localparam logic [7:0]  LAST_W   = 8'(N_WORDS - 1);
  localparam logic [13:0] ADDR_LIM = 14'(N_WORDS * 32);
  localparam logic [12:0] UNUSED   = 13'h1FFF;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ERR, OUTPUT} state_t;

  // Valid/ready: a transfer happens on a posedge where valid and ready are both 1;
  // a producer holds its data stable while valid is high and ready is low.

  state_t      state_q, state_d;
  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]  rd_ptr_q, rd_ptr_d;
  logic        err_latched_q, err_latched_d;
  logic [3:0]  serr_q, serr_d;
  logic [12:0] aadd_q [8];
  logic [12:0] aadd_d [8];
  logic [12:0] aadd_in [8];
  logic [31:0] dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        dout_last_q, dout_last_d;
  logic        dout_fail_q, dout_fail_d;
  logic        err_drop_q, err_drop_d;
  logic [31:0] buf_q [N_WORDS];
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] mask;
  logic        beat, err_take, out_adv;

  assign aadd_in[0] = aadd1;
  assign aadd_in[1] = aadd2;
  assign aadd_in[2] = aadd3;
  assign aadd_in[3] = aadd4;
  assign aadd_in[4] = aadd5;
  assign aadd_in[5] = aadd6;
  assign aadd_in[6] = aadd7;
  assign aadd_in[7] = aadd8;

  assign din_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign beat       = din_valid && din_ready;
  assign err_take   = err_valid && !err_latched_q && (state_q != OUTPUT);
  assign out_adv    = !dout_valid_q || dout_ready;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_fail  = dout_fail_q;
  assign err_drop   = err_drop_q;
  assign state_dbg  = state_q;

  // Duplicate addresses OR into the mask so a repeated location flips only once.
  always_comb begin
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) < serr_q) && (aadd_q[i] != UNUSED) && ({1'b0, aadd_q[i]} < ADDR_LIM) &&
          (aadd_q[i][12:5] == rd_ptr_q))
        mask[aadd_q[i][4:0]] = 1'b1;
    end
    if (serr_q > 4'd8) mask = '0;
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    err_latched_d = err_latched_q;
    serr_d        = serr_q;
    aadd_d        = aadd_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    dout_last_d   = dout_last_q;
    dout_fail_d   = dout_fail_q;
    err_drop_d    = err_valid && !err_take;
    wr_en         = 1'b0;
    wr_addr       = wr_ptr_q;
    if (err_take) begin
      err_latched_d = 1'b1;
      serr_d        = serr;
      aadd_d        = aadd_in;
    end
    case (state_q)
      IDLE: begin
        if (beat) begin
          wr_en    = 1'b1;
          wr_addr  = 8'd0;
          wr_ptr_d = 8'd1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST_W)
            state_d = (err_latched_q || err_take) ? OUTPUT : WAIT_ERR;
          else
            wr_ptr_d = wr_ptr_q + 8'd1;
        end
      end
      WAIT_ERR: begin
        if (err_take) state_d = OUTPUT;
      end
      OUTPUT: begin
        if (dout_valid_q && dout_last_q && dout_ready) begin
          state_d       = IDLE;
          wr_ptr_d      = 8'd0;
          rd_ptr_d      = 8'd0;
          err_latched_d = 1'b0;
          serr_d        = 4'd0;
          for (int i = 0; i < 8; i++) aadd_d[i] = UNUSED;
          dout_valid_d  = 1'b0;
          dout_last_d   = 1'b0;
          dout_fail_d   = 1'b0;
        end else if (out_adv) begin
          // rd_ptr parks on the last word; the final handshake clears it.
          dout_d       = buf_q[rd_ptr_q] ^ mask;
          dout_valid_d = 1'b1;
          dout_last_d  = (rd_ptr_q == LAST_W);
          dout_fail_d  = (serr_q > 4'd8);
          if (rd_ptr_q != LAST_W) rd_ptr_d = rd_ptr_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= 8'd0;
      rd_ptr_q      <= 8'd0;
      err_latched_q <= 1'b0;
      serr_q        <= 4'd0;
      for (int i = 0; i < 8; i++) aadd_q[i] <= UNUSED;
      dout_q        <= 32'd0;
      dout_valid_q  <= 1'b0;
      dout_last_q   <= 1'b0;
      dout_fail_q   <= 1'b0;
      err_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_latched_q <= err_latched_d;
      serr_q        <= serr_d;
      aadd_q        <= aadd_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      dout_last_q   <= dout_last_d;
      dout_fail_q   <= dout_fail_d;
      err_drop_q    <= err_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= din;
  end

endmodule

// File: tb/tb_bch_error_corrector.sv
// Randomized bench for bch_error_corrector: blocks are checked against a
// bit-address flip model, including timing, backpressure, drops and reset.
module tb_bch_error_corrector;

  localparam int NW = 132;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din_valid = 1'b0;
  logic [31:0] din = '0;
  logic        din_ready;
  logic        err_valid = 1'b0;
  logic [3:0]  serr = '0;
  logic [12:0] aadd [8];
  logic        dout_valid;
  logic [31:0] dout;
  logic        dout_last;
  logic        dout_ready = 1'b0;
  logic        dout_fail;
  logic        err_drop;
  logic [1:0]  state_dbg;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] data_a [NW];
  logic [3:0]  t_serr;
  logic [12:0] t_addr [8];

  always #5 clk = ~clk;

  bch_error_corrector #(.N_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .err_valid(err_valid), .serr(serr),
    .aadd1(aadd[0]), .aadd2(aadd[1]), .aadd3(aadd[2]), .aadd4(aadd[3]),
    .aadd5(aadd[4]), .aadd6(aadd[5]), .aadd7(aadd[6]), .aadd8(aadd[7]),
    .dout_valid(dout_valid), .dout(dout), .dout_last(dout_last), .dout_ready(dout_ready),
    .dout_fail(dout_fail), .err_drop(err_drop), .state_dbg(state_dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: each used, in-range location sets its bit in a per-word flip set.
  function automatic void build_expected();
    logic [31:0] flip [NW];
    for (int w = 0; w < NW; w++) flip[w] = '0;
    if (t_serr <= 4'd8) begin
      for (int i = 0; i < int'(t_serr); i++) begin
        int a;
        a = int'(t_addr[i]);
        if (a != 8191 && a < NW * 32) flip[a / 32][a % 32] = 1'b1;
      end
    end
    exp_q.delete();
    for (int w = 0; w < NW; w++) exp_q.push_back(data_a[w] ^ flip[w]);
  endfunction

  task automatic set_err_inputs();
    serr = t_serr;
    for (int i = 0; i < 8; i++) aadd[i] = t_addr[i];
  endtask

  task automatic rand_data();
    for (int w = 0; w < NW; w++) data_a[w] = $urandom;
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < 8; i++)
      t_addr[i] = ($urandom_range(0, 4) == 0) ? 13'd8191 : 13'($urandom_range(0, 4300));
  endtask

  task automatic load_block(input int err_at, input bit gaps);
    for (int b = 0; b < NW; b++) begin
      @(negedge clk);
      din_valid = 1'b0;
      err_valid = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      check_eq("din_ready_load", din_ready, 1);
      din_valid = 1'b1;
      din = data_a[b];
      if (b == err_at) begin
        set_err_inputs();
        err_valid = 1'b1;
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    err_valid = 1'b0;
  endtask

  task automatic drain(input int n_words, input bit rand_ready);
    int got = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_dout = '0;
    logic [31:0] e;
    while (got < n_words && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check_eq("hold_valid", dout_valid, 1);
        check_eq("hold_dout", dout, prev_dout);
      end
      dout_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("dout", dout, e);
          check_eq("dout_last", dout_last, (got == NW - 1));
          check_eq("dout_fail", dout_fail, (t_serr > 4'd8));
        end
        got++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
    end
    if (got < n_words) check_eq("drain_timeout", got, n_words);
  endtask

  // mode 0: error set during load at beat err_at; 1: 10 cycles after load; 2: late plus a dropped second set
  task automatic run_block(input int mode, input int err_at, input bit rand_ready, input bit full);
    build_expected();
    dout_ready = 1'b0;
    load_block((mode == 0) ? err_at : -1, 1'b1);
    if (mode == 0) begin
      check_eq("valid_early_n1", dout_valid, 0);
      @(negedge clk);
      check_eq("first_valid_early", dout_valid, 1);
    end else begin
      check_eq("din_ready_wait", din_ready, 0);
      check_eq("valid_wait", dout_valid, 0);
      repeat (9) @(negedge clk);
      set_err_inputs();
      err_valid = 1'b1;
      @(negedge clk);
      check_eq("valid_late_n1", dout_valid, 0);
      if (mode == 2) begin
        serr = 4'd8;
        for (int i = 0; i < 8; i++) aadd[i] = 13'd7;
        err_valid = 1'b1;
      end else begin
        err_valid = 1'b0;
      end
      @(negedge clk);
      err_valid = 1'b0;
      check_eq("first_valid_late", dout_valid, 1);
      if (mode == 2) begin
        check_eq("err_drop_pulse", err_drop, 1);
        @(negedge clk);
        check_eq("err_drop_clear", err_drop, 0);
      end
    end
    if (full) begin
      drain(NW, rand_ready);
      @(negedge clk);
      dout_ready = 1'b0;
      check_eq("din_ready_after", din_ready, 1);
      check_eq("valid_after", dout_valid, 0);
      check_eq("state_after", state_dbg, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) aadd[i] = 13'd8191;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_din_ready", din_ready, 1);
    check_eq("rst_dout_valid", dout_valid, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_dout_last", dout_last, 0);
    check_eq("rst_dout_fail", dout_fail, 0);
    check_eq("rst_err_drop", err_drop, 0);
    check_eq("rst_state", state_dbg, 0);

    // error-free counting block, error set arrives mid-load
    for (int w = 0; w < NW; w++) data_a[w] = w;
    t_serr = 4'd0;
    for (int i = 0; i < 8; i++) t_addr[i] = 13'd8191;
    run_block(0, 50, 1'b0, 1'b1);

    // eight errors, late error set, second set dropped
    rand_data();
    t_serr = 4'd8;
    t_addr[0] = 13'd0;    t_addr[1] = 13'd31;   t_addr[2] = 13'd32; t_addr[3] = 13'd100;
    t_addr[4] = 13'd4223; t_addr[5] = 13'd4000; t_addr[6] = 13'd64; t_addr[7] = 13'd65;
    run_block(2, -1, 1'b1, 1'b1);

    // duplicate addresses and slots beyond serr
    rand_data();
    rand_addrs();
    t_serr = 4'd2;
    t_addr[0] = 13'd37; t_addr[1] = 13'd37; t_addr[2] = 13'd5;
    run_block(0, $urandom_range(0, NW - 1), 1'b1, 1'b1);

    // out-of-range and unused addresses
    rand_data();
    rand_addrs();
    t_serr = 4'd3;
    t_addr[0] = 13'd5000; t_addr[1] = 13'd8191; t_addr[2] = 13'd4223;
    run_block(1, -1, 1'b0, 1'b1);

    // uncorrectable block
    rand_data();
    rand_addrs();
    t_serr = 4'd9;
    run_block(0, NW - 1, 1'b1, 1'b1);

    for (int k = 0; k < 3; k++) begin
      rand_data();
      rand_addrs();
      t_serr = 4'($urandom_range(0, 8));
      run_block($urandom_range(0, 2), $urandom_range(0, NW - 1), 1'b1, 1'b1);
    end

    // reset in the middle of output
    rand_data();
    rand_addrs();
    t_serr = 4'($urandom_range(1, 8));
    run_block(0, 10, 1'b0, 1'b0);
    drain(60, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    dout_ready = 1'b0;
    #1;
    check_eq("rst_mid_valid", dout_valid, 0);
    check_eq("rst_mid_state", state_dbg, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("rst_mid_din_ready", din_ready, 1);
    check_eq("rst_mid_no_valid", dout_valid, 0);

    rand_data();
    rand_addrs();
    t_serr = 4'($urandom_range(0, 8));
    run_block(1, -1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
